// File: rtl/ahb_trans_sequencer.sv
// ahb_trans_sequencer
//   AHB master transfer sequencer for the AXI-to-AHB bridge. It pops one
//   arbitrated AXI address command (AW or AR) and generates the full AHB
//   address-phase stream for it. That covers beat counting, INCR/WRAP address
//   stepping, BUSY insertion while write data is starved, 1 KB boundary
//   splitting and splitting FIXED bursts into SINGLE transfers.
//
//   Optional build macro: AHB_ERR_ABORT_EN. When it is defined, an AHB ERROR
//   response aborts the rest of the burst. When it is undefined, h_resp_i is
//   ignored.
//
// Ports
//   h_clk_i, h_reset_i      clock, synchronous active-high reset
//   cmd_*_i / cmd_ready_o   command FIFO pop interface
//   w_valid_i / w_pop_o     write-data FIFO status and pop
//   h_ready_i, h_resp_i     AHB HREADY / HRESP
//   h_trans_o .. h_write_o  AHB address-phase outputs
//   cmd_done_o, cmd_err_o   end-of-command pulse and its error qualifier
//
// State | meaning
//   S_IDLE  | waiting for a command; cmd_ready asserted
//   S_FIRST | next beat is the first of an AHB burst (NONSEQ, or IDLE if starved)
//   S_NEXT  | next beat continues the burst (SEQ, or BUSY if starved)

module ahb_trans_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int MAX_SIZE   = 2
) (
  input  logic                  h_clk_i,
  input  logic                  h_reset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [2:0]            cmd_size_i,
  input  logic [1:0]            cmd_burst_i,
  input  logic                  cmd_illegal_i,
  input  logic                  w_valid_i,
  output logic                  w_pop_o,
  input  logic                  h_ready_i,
  input  logic                  h_resp_i,
  output logic [1:0]            h_trans_o,
  output logic [ADDR_WIDTH-1:0] h_addr_o,
  output logic [2:0]            h_burst_o,
  output logic [2:0]            h_size_o,
  output logic                  h_write_o,
  output logic                  cmd_done_o,
  output logic                  cmd_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_NEXT  = 2'd2
  } state_e;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam int BW = LEN_WIDTH + 1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] mask_q;
  logic [2:0]            burst_q;
  logic [2:0]            size_q;
  logic                  write_q;
  logic                  fixed_q;
  logic                  wrap_q;
  logic [BW-1:0]         left_q;
  logic                  done_q;
  logic                  err_q;

  // ---------------- command decode (used only at load) ----------------
  logic [BW-1:0]         beats_d;
  logic                  len_2_d, len_4_d, len_8_d, len_16_d;
  logic                  illegal_d;
  logic [12:0]           span_d;
  logic                  cross_1k_d;
  logic [2:0]            burst_enc_d;
  logic [ADDR_WIDTH-1:0] mask_d;

  assign beats_d  = {1'b0, cmd_len_i} + BW'(1);
  assign len_2_d  = (beats_d == BW'(2));
  assign len_4_d  = (beats_d == BW'(4));
  assign len_8_d  = (beats_d == BW'(8));
  assign len_16_d = (beats_d == BW'(16));

  assign illegal_d = cmd_illegal_i
                   | (cmd_burst_i == 2'b11)
                   | (cmd_size_i > 3'(MAX_SIZE))
                   | ((cmd_burst_i == 2'b10) & ~(len_2_d | len_4_d | len_8_d | len_16_d));

  // Span only matters for 4/8/16 beats, so 13 bits cover 16 beats of 128 bytes.
  assign span_d     = 13'(beats_d) << cmd_size_i;
  assign cross_1k_d = (({3'b000, cmd_addr_i[9:0]} + span_d) > 13'd1024);

  always_comb begin
    burst_enc_d = 3'b001;
    if (cmd_burst_i == 2'b00 || beats_d == BW'(1)) begin
      burst_enc_d = 3'b000;
    end else if (cmd_burst_i == 2'b10) begin
      if (len_4_d)       burst_enc_d = 3'b010;
      else if (len_8_d)  burst_enc_d = 3'b100;
      else if (len_16_d) burst_enc_d = 3'b110;
    end else if (!cross_1k_d) begin
      if (len_4_d)       burst_enc_d = 3'b011;
      else if (len_8_d)  burst_enc_d = 3'b101;
      else if (len_16_d) burst_enc_d = 3'b111;
    end
  end

  // A non-wrapping burst uses an all-ones mask, so one expression serves both.
  assign mask_d = (cmd_burst_i == 2'b10)
                ? ((ADDR_WIDTH'(beats_d) << cmd_size_i) - ADDR_WIDTH'(1))
                : '1;

  // ---------------- per-beat datapath ----------------
  logic [ADDR_WIDTH-1:0] addr_sum_d;
  logic [ADDR_WIDTH-1:0] addr_nxt_d;
  logic                  split_d;
  logic                  accept_d;
  logic                  last_d;
  logic                  abort_d;
  logic                  have_data_d;

  assign addr_sum_d = addr_q + (ADDR_WIDTH'(1) << size_q);
  assign addr_nxt_d = fixed_q ? addr_q : ((addr_q & ~mask_q) | (addr_sum_d & mask_q));

  // An undefined-length INCR restarts with NONSEQ at each 1 KB boundary and,
  // for WRAP2, at the wrap point. FIXED bursts always restart.
  assign split_d = fixed_q
                 | ((burst_q == 3'b001)
                    & ((addr_nxt_d[9:0] == 10'd0)
                       | (wrap_q & ((addr_nxt_d & mask_q) == '0))));

  assign have_data_d = ~write_q | w_valid_i;

  always_comb begin
    h_trans_o = TR_IDLE;
    case (state_q)
      S_FIRST: h_trans_o = have_data_d ? TR_NONSEQ : TR_IDLE;
      S_NEXT:  h_trans_o = have_data_d ? TR_SEQ : TR_BUSY;
      default: h_trans_o = TR_IDLE;
    endcase
    if (h_reset_i) h_trans_o = TR_IDLE;
  end

  assign accept_d    = h_trans_o[1] & h_ready_i;
  assign last_d      = (left_q == BW'(1));
  assign w_pop_o     = accept_d & write_q;
  assign cmd_ready_o = (state_q == S_IDLE) & ~h_reset_i;

`ifdef AHB_ERR_ABORT_EN
  // First cycle of a two-cycle ERROR response.
  assign abort_d = (state_q != S_IDLE) & h_resp_i & ~h_ready_i;
`else
  logic unused_resp;
  assign unused_resp = h_resp_i;
  assign abort_d     = 1'b0;
`endif

  // ---------------- FSM and registered outputs ----------------
  always_ff @(posedge h_clk_i) begin
    if (h_reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      burst_q <= 3'b000;
      size_q  <= 3'b000;
      write_q <= 1'b0;
      fixed_q <= 1'b0;
      wrap_q  <= 1'b0;
      left_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            if (illegal_d) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              addr_q  <= cmd_addr_i;
              mask_q  <= mask_d;
              burst_q <= burst_enc_d;
              size_q  <= cmd_size_i;
              write_q <= cmd_write_i;
              fixed_q <= (cmd_burst_i == 2'b00);
              wrap_q  <= (cmd_burst_i == 2'b10);
              left_q  <= beats_d;
              state_q <= S_FIRST;
            end
          end
        end
        S_FIRST, S_NEXT: begin
          if (abort_d) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (accept_d) begin
            addr_q <= addr_nxt_d;
            left_q <= left_q - BW'(1);
            if (last_d) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end else if (split_d) begin
              state_q <= S_FIRST;
            end else begin
              state_q <= S_NEXT;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign h_addr_o   = addr_q;
  assign h_burst_o  = burst_q;
  assign h_size_o   = size_q;
  assign h_write_o  = write_q;
  assign cmd_done_o = done_q;
  assign cmd_err_o  = err_q;

endmodule

// File: tb/tb_ahb_trans_sequencer.sv
module tb_ahb_trans_sequencer;

  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] B = 2'b01;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] S = 2'b11;
  localparam logic [1:0] FIX  = 2'b00;
  localparam logic [1:0] INCR = 2'b01;
  localparam logic [1:0] WRAP = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_illegal;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        w_valid, w_pop, h_ready, h_resp;
  logic [1:0]  h_trans;
  logic [31:0] h_addr;
  logic [2:0]  h_burst, h_size;
  logic        h_write, cmd_done, cmd_err;

  always #5 clk = ~clk;

  ahb_trans_sequencer #(.ADDR_WIDTH(32), .LEN_WIDTH(8), .MAX_SIZE(2)) dut (
    .h_clk_i(clk), .h_reset_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_size_i(cmd_size),
    .cmd_burst_i(cmd_burst), .cmd_illegal_i(cmd_illegal),
    .w_valid_i(w_valid), .w_pop_o(w_pop), .h_ready_i(h_ready), .h_resp_i(h_resp),
    .h_trans_o(h_trans), .h_addr_o(h_addr), .h_burst_o(h_burst), .h_size_o(h_size),
    .h_write_o(h_write), .cmd_done_o(cmd_done), .cmd_err_o(cmd_err)
  );

  typedef struct {
    logic        rst, cv, cw;
    logic [31:0] ca;
    logic [7:0]  cl;
    logic [2:0]  cs;
    logic [1:0]  cb;
    logic        ci, wv, hr, hresp;
    logic [1:0]  et;
    logic [31:0] ea;
    logic [2:0]  eb;
    logic        ew;
    logic [2:0]  es;
    logic        chk, erdy, epop, edone, eerr;
  } vec_t;

  vec_t vecs[$];

  // Pending command / reset, consumed by the next step() entry.
  logic        p_v = 1'b0, p_rst = 1'b0, p_w = 1'b0, p_il = 1'b0;
  logic [31:0] p_a = '0;
  logic [7:0]  p_l = '0;
  logic [2:0]  p_s = '0;
  logic [1:0]  p_b = '0;
  logic        cur_w = 1'b0;
  logic [2:0]  cur_s = '0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic compare(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, got, exp);
    else n_pass++;
  endtask

  task automatic cmd(input logic w, input logic [31:0] a, input logic [7:0] l,
                     input logic [2:0] s, input logic [1:0] b, input logic il);
    p_v = 1'b1; p_w = w; p_a = a; p_l = l; p_s = s; p_b = b; p_il = il;
    cur_w = w; cur_s = s;
  endtask

  task automatic hold_rst();
    p_rst = 1'b1;
  endtask

  task automatic step(input logic wv, input logic hr, input logic hresp,
                      input logic [1:0] et, input logic [31:0] ea, input logic [2:0] eb,
                      input logic erdy, input logic epop, input logic edone, input logic eerr);
    vec_t v;
    v.rst = p_rst; v.cv = p_v; v.cw = p_w; v.ca = p_a; v.cl = p_l; v.cs = p_s;
    v.cb = p_b; v.ci = p_il; v.wv = wv; v.hr = hr; v.hresp = hresp;
    v.et = et; v.ea = ea; v.eb = eb; v.ew = cur_w; v.es = cur_s;
    v.chk = (et != I); v.erdy = erdy; v.epop = epop; v.edone = edone; v.eerr = eerr;
    vecs.push_back(v);
    p_v = 1'b0; p_rst = 1'b0;
  endtask

  task automatic rst_v();
    vec_t v;
    v.rst = 1'b1; v.cv = 1'b0; v.cw = 1'b0; v.ca = '0; v.cl = '0; v.cs = '0;
    v.cb = '0; v.ci = 1'b0; v.wv = 1'b0; v.hr = 1'b1; v.hresp = 1'b0;
    v.et = I; v.ea = '0; v.eb = '0; v.ew = 1'b0; v.es = '0;
    v.chk = 1'b1; v.erdy = 1'b0; v.epop = 1'b0; v.edone = 1'b0; v.eerr = 1'b0;
    vecs.push_back(v);
  endtask

  initial begin
    // reset state and idle
    rst_v();
    step(0,1,0, I,0,0, 1,0,0,0);
    // INCR4 read at 0x100
    cmd(0,32'h100,8'd3,3'd2,INCR,0); step(0,1,0, I,0,0, 1,0,0,0);
    step(0,1,0, N,32'h100,3'b011, 0,0,0,0);
    step(0,1,0, S,32'h104,3'b011, 0,0,0,0);
    step(0,1,0, S,32'h108,3'b011, 0,0,0,0);
    step(0,1,0, S,32'h10C,3'b011, 0,0,0,0);
    // done, back-to-back WRAP4 write at 0x1C with data starvation
    cmd(1,32'h1C,8'd3,3'd2,WRAP,0); step(1,1,0, I,0,0, 1,0,1,0);
    step(1,1,0, N,32'h1C,3'b010, 0,1,0,0);
    step(1,1,0, S,32'h10,3'b010, 0,1,0,0);
    step(0,1,0, B,32'h14,3'b010, 0,0,0,0);
    step(0,1,0, B,32'h14,3'b010, 0,0,0,0);
    step(1,1,0, S,32'h14,3'b010, 0,1,0,0);
    step(1,1,0, S,32'h18,3'b010, 0,1,0,0);
    // INCR8 read across 1 KB -> INCR, re-NONSEQ at 0x400
    cmd(0,32'h3F0,8'd7,3'd2,INCR,0); step(0,1,0, I,0,0, 1,0,1,0);
    step(0,1,0, N,32'h3F0,3'b001, 0,0,0,0);
    step(0,1,0, S,32'h3F4,3'b001, 0,0,0,0);
    step(0,1,0, S,32'h3F8,3'b001, 0,0,0,0);
    step(0,1,0, S,32'h3FC,3'b001, 0,0,0,0);
    step(0,1,0, N,32'h400,3'b001, 0,0,0,0);
    step(0,1,0, S,32'h404,3'b001, 0,0,0,0);
    step(0,1,0, S,32'h408,3'b001, 0,0,0,0);
    step(0,1,0, S,32'h40C,3'b001, 0,0,0,0);
    // FIXED len=2 at 0x40, stall on beat 2
    cmd(0,32'h40,8'd2,3'd2,FIX,0); step(0,1,0, I,0,0, 1,0,1,0);
    step(0,1,0, N,32'h40,3'b000, 0,0,0,0);
    step(0,0,0, N,32'h40,3'b000, 0,0,0,0);
    step(0,1,0, N,32'h40,3'b000, 0,0,0,0);
    step(0,1,0, N,32'h40,3'b000, 0,0,0,0);
    // illegal commands: flag, burst 11, oversize, WRAP with 3 beats
    cmd(0,32'h80,8'd3,3'd2,INCR,1); step(0,1,0, I,0,0, 1,0,1,0);
    cmd(0,32'h80,8'd3,3'd2,2'b11,0); step(0,1,0, I,0,0, 1,0,1,1);
    cmd(0,32'h80,8'd3,3'd3,INCR,0); step(0,1,0, I,0,0, 1,0,1,1);
    cmd(0,32'h80,8'd2,3'd2,WRAP,0); step(0,1,0, I,0,0, 1,0,1,1);
    // WRAP2 read at 0xC -> INCR, re-NONSEQ at wrap point
    cmd(0,32'hC,8'd1,3'd2,WRAP,0); step(0,1,0, I,0,0, 1,0,1,1);
    step(0,1,0, N,32'hC,3'b001, 0,0,0,0);
    step(0,1,0, N,32'h8,3'b001, 0,0,0,0);
    // SINGLE write, starved for a cycle in S_FIRST
    cmd(1,32'h200,8'd0,3'd2,INCR,0); step(0,1,0, I,0,0, 1,0,1,0);
    step(0,1,0, I,0,0, 0,0,0,0);
    step(1,1,0, N,32'h200,3'b000, 0,1,0,0);
    // INCR4 ending exactly at 1 KB keeps INCR4
    cmd(0,32'h3F0,8'd3,3'd2,INCR,0); step(0,1,0, I,0,0, 1,0,1,0);
    step(0,1,0, N,32'h3F0,3'b011, 0,0,0,0);
    step(0,1,0, S,32'h3F4,3'b011, 0,0,0,0);
    step(0,1,0, S,32'h3F8,3'b011, 0,0,0,0);
    step(0,1,0, S,32'h3FC,3'b011, 0,0,0,0);
    // address wraps modulo 2^32
    cmd(0,32'hFFFFFFFC,8'd1,3'd2,INCR,0); step(0,1,0, I,0,0, 1,0,1,0);
    step(0,1,0, N,32'hFFFFFFFC,3'b001, 0,0,0,0);
    step(0,1,0, N,32'h0,3'b001, 0,0,0,0);
    // reset mid-burst: no done pulse
    cmd(0,32'h100,8'd3,3'd2,INCR,0); step(0,1,0, I,0,0, 1,0,1,0);
    step(0,1,0, N,32'h100,3'b011, 0,0,0,0);
    hold_rst(); step(0,1,0, I,0,0, 0,0,0,0);
    rst_v();
    // ERROR response on beat 3
    cmd(0,32'h500,8'd3,3'd2,INCR,0); step(0,1,0, I,0,0, 1,0,0,0);
    step(0,1,0, N,32'h500,3'b011, 0,0,0,0);
    step(0,1,0, S,32'h504,3'b011, 0,0,0,0);
    step(0,0,1, S,32'h508,3'b011, 0,0,0,0);
`ifdef AHB_ERR_ABORT_EN
    cmd(0,32'h600,8'd0,3'd2,INCR,0); step(0,1,1, I,0,0, 1,0,1,1);
    step(0,1,0, N,32'h600,3'b000, 0,0,0,0);
    step(0,1,0, I,0,0, 1,0,1,0);
`else
    step(0,1,1, S,32'h508,3'b011, 0,0,0,0);
    step(0,1,0, S,32'h50C,3'b011, 0,0,0,0);
    step(0,1,0, I,0,0, 1,0,1,0);
`endif
    step(0,1,0, I,0,0, 1,0,0,0);

    // apply table
    rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    cmd_size = '0; cmd_burst = '0; cmd_illegal = 0; w_valid = 0; h_ready = 1; h_resp = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; cmd_valid = vecs[i].cv; cmd_write = vecs[i].cw;
      cmd_addr = vecs[i].ca; cmd_len = vecs[i].cl; cmd_size = vecs[i].cs;
      cmd_burst = vecs[i].cb; cmd_illegal = vecs[i].ci; w_valid = vecs[i].wv;
      h_ready = vecs[i].hr; h_resp = vecs[i].hresp;
      #1;
      compare("cmd_ready", i, 32'(cmd_ready), 32'(vecs[i].erdy));
      compare("h_trans",   i, 32'(h_trans),   32'(vecs[i].et));
      compare("w_pop",     i, 32'(w_pop),     32'(vecs[i].epop));
      compare("cmd_done",  i, 32'(cmd_done),  32'(vecs[i].edone));
      compare("cmd_err",   i, 32'(cmd_err),   32'(vecs[i].eerr));
      if (vecs[i].chk) begin
        compare("h_addr",  i, h_addr,         vecs[i].ea);
        compare("h_burst", i, 32'(h_burst),   32'(vecs[i].eb));
        compare("h_write", i, 32'(h_write),   32'(vecs[i].ew));
        compare("h_size",  i, 32'(h_size),    32'(vecs[i].es));
      end
    end

    // Hand-written: INCR4 write at 0x700 with irregular w_valid / h_ready.
    begin
      int  beats = 0;
      int  pops  = 0;
      bit  seen_done = 0;
      @(negedge clk);
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h700; cmd_len = 8'd3;
      cmd_size = 3'd2; cmd_burst = INCR; cmd_illegal = 0; w_valid = 0; h_ready = 1;
      @(negedge clk);
      cmd_valid = 0;
      for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
        w_valid = (cyc % 3) != 1;
        h_ready = (cyc % 4) != 2;
        #1;
        if (h_trans[1] && h_ready) begin
          compare("hs_addr",  beats, h_addr, 32'h700 + 32'(4 * beats));
          compare("hs_trans", beats, 32'(h_trans), (beats == 0) ? 32'(N) : 32'(S));
          beats++;
        end
        if (w_pop) pops++;
        @(posedge clk); #1;
        if (cmd_done) seen_done = 1;
        @(negedge clk);
      end
      compare("hs_done",  0, 32'(seen_done), 32'd1);
      compare("hs_beats", 0, 32'(beats),     32'd4);
      compare("hs_pops",  0, 32'(pops),      32'd4);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
